// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the CPU data-memory interface.
// It takes one load or store at a time over a valid/ready request channel and
// performs the access on a little-endian array of 64-bit doublewords after
// LATENCY cycles. The result comes back over a valid/ready response channel.
// Optional build macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses fault. When it is undefined, the address is masked down to the
// natural alignment of the access size.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH_WORDS];

    // The access operands are the live request in IDLE (LATENCY==1 accesses
    // on the accept edge itself) and the latched request otherwise.
    logic        acc_write;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [1:0]  acc_size;
    logic        acc_uns;

    logic [2:0]    size_mask;
    logic [3:0]    nbytes;
    logic [2:0]    lane;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic [63:0]   rd_word;
    logic [63:0]   rd_shifted;
    logic [63:0]   load_val;
    logic [63:0]   wdata_shifted;
    logic [7:0]    byte_en;
    logic [63:0]   merged;
    logic          enter_resp;
    logic          mem_we;

    // Select the operands for the access that happens on the edge into RESP
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
        end else begin
            acc_write = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
        end
    end

    // Decode the address, check for faults, and extract and extend the load data
    always_comb begin
        size_mask = 3'b000;
        nbytes    = 4'd1;
        case (acc_size)
            2'b00: begin size_mask = 3'b000; nbytes = 4'd1; end
            2'b01: begin size_mask = 3'b001; nbytes = 4'd2; end
            2'b10: begin size_mask = 3'b011; nbytes = 4'd4; end
            default: begin size_mask = 3'b111; nbytes = 4'd8; end
        endcase
        misaligned   = |(acc_addr[2:0] & size_mask);
        out_of_range = (acc_addr[63:3] >= 61'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
        lane    = acc_addr[2:0];
        acc_err = out_of_range | misaligned;
`else
        lane    = acc_addr[2:0] & ~size_mask;
        acc_err = out_of_range;
`endif
        word_idx   = acc_addr[AW+2:3];
        rd_word    = mem[word_idx];
        rd_shifted = rd_word >> {lane, 3'b000};
        case (acc_size)
            2'b00:   load_val = {{56{rd_shifted[7]  & ~acc_uns}}, rd_shifted[7:0]};
            2'b01:   load_val = {{48{rd_shifted[15] & ~acc_uns}}, rd_shifted[15:0]};
            2'b10:   load_val = {{32{rd_shifted[31] & ~acc_uns}}, rd_shifted[31:0]};
            default: load_val = rd_shifted;
        endcase
        wdata_shifted = acc_wdata << {lane, 3'b000};
    end

    // Store merge: only the addressed bytes take new data
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign byte_en[gi] = (4'(gi) >= {1'b0, lane}) &&
                                 (4'(gi) < ({1'b0, lane} + nbytes));
            assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_shifted[gi*8 +: 8]
                                                   : rd_word[gi*8 +: 8];
        end
    endgenerate

    // Next-state, latch, and response logic for the IDLE/WAIT/RESP sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_write || acc_err) ? 64'd0 : load_val;
        end
    end

    assign mem_we = enter_resp && acc_write && !acc_err;

    // State and response registers; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array write; contents survive reset, but a store hit by reset is dropped
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[word_idx] <= merged;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the CPU data-memory interface.
- Accepts one load or store request at a time from the memory stage over a valid/ready handshake.
- Performs the access on an internal little-endian, doubleword-organised array after a fixed programmable latency.
- Returns the result over a valid/ready response channel, so the pipeline can stall on a multi-cycle memory.

Parameters:
- DEPTH_WORDS, 256, number of 64-bit doublewords in the array (power of two).
- LATENCY, 2, cycles from request accept to resp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data; the low bytes are used according to req_size.
- req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester consumes the response.
- resp_rdata  output  64  load result, extended to 64 bits; 0 for stores and errors.
- resp_err  output  1  access fault for this response.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, latency counter=0.
- Array contents are not altered by reset.
- Reset mid-operation: the pending request is dropped and a pending store is never written.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE); it is combinational from state only and never depends on req_valid.
- Accept: req_valid && req_ready at an edge.
  - Latch write, addr, wdata, size, unsigned.
  - If LATENCY==1, go to RESP; otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT: decrement the counter each cycle; when the counter==0, go to RESP on the next edge.
- Access timing: the array access happens on the edge entering RESP.
  - The store write and the read capture both occur there.
  - resp_valid is therefore first high exactly LATENCY cycles after the accept edge.
- RESP: resp_valid=1, and resp_rdata/resp_err are held stable until resp_valid && resp_ready.
  - On that edge: go to IDLE and clear resp_valid, resp_rdata, resp_err.
  - No new request is accepted in the same cycle; back-to-back throughput is one request per LATENCY+1 cycles minimum.
- Addressing:
  - word index = addr[63:3]; byte lane = addr[2:0]; little-endian.
  - Out of range when addr[63:3] >= DEPTH_WORDS; this sets err.
- Alignment: misaligned when addr mod (1<<size) != 0 (handling depends on DMEM_MISALIGN_TRAP_EN).
- Loads: extract 1/2/4/8 bytes starting at the lane; sign- or zero-extend to 64 bits (doubleword is unaffected).
- Stores: read-modify-write of the target doubleword; only the addressed bytes change; resp_rdata=0.
- Error response: no array write, resp_rdata=0, resp_err=1; the handshake proceeds normally.
- req_* inputs are ignored outside IDLE; changing them during WAIT/RESP has no effect.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access is an error response (no write, rdata 0, err 1).
- Undefined: addr low bits are masked to the size alignment (addr & ~((1<<size)-1)) before access; err is raised only for out-of-range addresses.

Test Plan:
- Store/load round trip (LATENCY=2):
  - Store dword 0x0123456789ABCDEF to addr 0x40; resp_valid rises 2 cycles after accept, with rdata 0 and err 0.
  - Load dword from 0x40 -> rdata 0x0123456789ABCDEF.
- Sub-word extension:
  - After the above, load byte at 0x40, signed -> 0xFFFFFFFFFFFFFFEF; unsigned -> 0x00000000000000EF.
  - Load half at 0x46, signed -> 0x0000000000000123.
- Byte-merge store:
  - Store byte 0xAA to 0x43, then load dword at 0x40 -> 0x01234567AAABCDEF.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles in RESP; resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0.
  - Raise resp_ready; IDLE is reached the next cycle.
- Faults:
  - Load from addr 256*8=0x800 -> err 1, rdata 0.
  - Store half to 0x41: with DMEM_MISALIGN_TRAP_EN -> err 1 and memory unchanged; without it -> write lands at 0x40, err 0.
- Reset mid-operation:
  - Assert reset in WAIT of a store of 0xFF..FF to 0x80; a subsequent load at 0x80 returns the prior value.
  - All outputs are at reset values the cycle after reset.
